// File: rtl/mips_regdest_pkg.sv
// Shared destination-select codes and default widths for the register
// write-back path. Used by regdest_sel and regdest_wb_queue.
package mips_regdest_pkg;

   typedef enum logic [1:0] {
      DEST_RT   = 2'b00,
      DEST_RD   = 2'b01,
      DEST_LINK = 2'b10,
      DEST_ZERO = 2'b11
   } dest_sel_e;

   localparam int REG_ADDR_W_DEF = 5;
   localparam int LINK_REG_DEF   = 31;

endpackage

// File: rtl/regdest_sel.sv
// Write-back destination select: rt, rd, link register or zero (no write).
// Purely combinational so the single-cycle datapath can reuse it directly.
module regdest_sel
   import mips_regdest_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int LINK_REG   = LINK_REG_DEF
) (
   input  logic [1:0]            dest_sel,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic [REG_ADDR_W-1:0] rd,
   output logic [REG_ADDR_W-1:0] addr
);

   localparam logic [REG_ADDR_W-1:0] LINK_A = REG_ADDR_W'(LINK_REG);

   // Decode the select code into a register address
   always_comb begin
      addr = '0;
      case (dest_sel)
         DEST_RT:   addr = rt;
         DEST_RD:   addr = rd;
         DEST_LINK: addr = LINK_A;
         default:   addr = '0;
      endcase
   end

endmodule

// File: rtl/regdest_wb_queue.sv
// In-order queue of pending write-back destinations for multicycle ops.
// The destination is chosen at issue, held until the op completes, and a
// busy mask / two-port hazard query is exported for stall logic.
// Optional macro REGDEST_WB_BYPASS_EN: when the queue is empty, a push and
// pop in the same cycle forward the selected destination without storing.
module regdest_wb_queue
   import mips_regdest_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int DEPTH      = 4,
   parameter int LINK_REG   = LINK_REG_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [1:0]                   dest_sel,
   input  logic [REG_ADDR_W-1:0]        inst_rt,
   input  logic [REG_ADDR_W-1:0]        inst_rd,
   input  logic                         push,
   output logic                         push_ready,
   input  logic                         pop,
   output logic                         pop_valid,
   output logic [REG_ADDR_W-1:0]        wb_dest,
   output logic [$clog2(DEPTH):0]       count,
   output logic [(2**REG_ADDR_W)-1:0]   busy_mask,
   input  logic [REG_ADDR_W-1:0]        query_a,
   input  logic [REG_ADDR_W-1:0]        query_b,
   output logic                         hazard
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [REG_ADDR_W-1:0] sel_addr;
   logic [REG_ADDR_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      vld;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic                  full;
   logic                  empty;
   logic                  bypass;
   logic                  push_acc;
   logic                  pop_acc;
   logic                  head_vld;
   logic [REG_ADDR_W-1:0] head_dest;

   regdest_sel #(
      .REG_ADDR_W (REG_ADDR_W),
      .LINK_REG   (LINK_REG)
   ) u_sel (
      .dest_sel (dest_sel),
      .rt       (inst_rt),
      .rd       (inst_rd),
      .addr     (sel_addr)
   );

   assign full       = (count == CW'(DEPTH));
   assign empty      = (count == '0);
   assign push_ready = !full;

   // Stored head: valid bit and address come straight from registers
   assign head_vld  = vld[rd_ptr];
   assign head_dest = head_vld ? mem[rd_ptr] : '0;

`ifdef REGDEST_WB_BYPASS_EN
   // Empty queue with push+pop: hand the destination straight through
   assign bypass    = empty && push && pop;
   assign pop_valid = head_vld || bypass;
   assign wb_dest   = bypass ? sel_addr : head_dest;
`else
   assign bypass    = 1'b0;
   assign pop_valid = head_vld;
   assign wb_dest   = head_dest;
`endif

   // Pop only consumes a stored entry; a bypassed pop touches no state
   assign push_acc = push && push_ready && !bypass;
   assign pop_acc  = pop && head_vld;

   // Pointers, occupancy and per-entry valid bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else begin
         if (push_acc) begin
            wr_ptr      <= wr_ptr + PW'(1);
            vld[wr_ptr] <= 1'b1;
         end
         if (pop_acc) begin
            rd_ptr      <= rd_ptr + PW'(1);
            vld[rd_ptr] <= 1'b0;
         end
         case ({push_acc, pop_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are qualified by vld so no reset is needed
   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_ptr] <= sel_addr;
   end

   // Busy mask from stored entries only; register 0 never reads as busy
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i] && (mem[i] != '0)) busy_mask[mem[i]] = 1'b1;
      end
   end

   assign hazard = busy_mask[query_a] | busy_mask[query_b];

endmodule

// File: tb/tb_regdest_wb_queue.sv
// Directed bench for regdest_wb_queue (default parameters, DEPTH=4).
// Builds with or without REGDEST_WB_BYPASS_EN; expectations follow the build.
module tb_regdest_wb_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  dest_sel;
   logic [4:0]  inst_rt, inst_rd;
   logic        push, pop;
   logic        push_ready, pop_valid, hazard;
   logic [4:0]  wb_dest;
   logic [2:0]  count;
   logic [31:0] busy_mask;
   logic [4:0]  query_a, query_b;

   int checks   = 0;
   int failures = 0;

   regdest_wb_queue dut (
      .clk        (clk),
      .reset      (reset),
      .dest_sel   (dest_sel),
      .inst_rt    (inst_rt),
      .inst_rd    (inst_rd),
      .push       (push),
      .push_ready (push_ready),
      .pop        (pop),
      .pop_valid  (pop_valid),
      .wb_dest    (wb_dest),
      .count      (count),
      .busy_mask  (busy_mask),
      .query_a    (query_a),
      .query_b    (query_b),
      .hazard     (hazard)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [1:0] sel, input logic [4:0] rt, input logic [4:0] rd);
      dest_sel = sel; inst_rt = rt; inst_rd = rd; push = 1'b1;
      step();
      push = 1'b0;
   endtask

   task automatic do_pop();
      pop = 1'b1;
      step();
      pop = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      checks++;
      if (pop_valid !== 1'b0 || wb_dest !== 5'd0 || count !== 3'd0 ||
          busy_mask !== 32'd0 || hazard !== 1'b0 || push_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: pv=%b wb=%0d cnt=%0d mask=%h hz=%b pr=%b, need 0/0/0/0/0/1",
                  pop_valid, wb_dest, count, busy_mask, hazard, push_ready);
      end
      step();
      reset = 1'b0;
      step();
      do_push(2'b00, 5'd1, 5'd0);
      do_push(2'b00, 5'd2, 5'd0);
      do_push(2'b00, 5'd3, 5'd0);
      checks++;
      if (count !== 3'd3) begin
         failures++;
         $display("FAIL reset_prefill_count: got %0d need 3", count);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (pop_valid !== 1'b0 || wb_dest !== 5'd0 || count !== 3'd0 ||
          busy_mask !== 32'd0 || hazard !== 1'b0 || push_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_midop: pv=%b wb=%0d cnt=%0d mask=%h hz=%b pr=%b, need 0/0/0/0/0/1",
                  pop_valid, wb_dest, count, busy_mask, hazard, push_ready);
      end
      #1 reset = 1'b0;
      step();
      do_push(2'b01, 5'd0, 5'd9);
      checks++;
      if (wb_dest !== 5'd9 || pop_valid !== 1'b1 || count !== 3'd1) begin
         failures++;
         $display("FAIL reset_then_push: wb=%0d pv=%b cnt=%0d need 9/1/1", wb_dest, pop_valid, count);
      end
      do_pop();
   endtask

   task automatic test_select();
      logic [4:0] exp_d [4];
      exp_d[0] = 5'd5; exp_d[1] = 5'd12; exp_d[2] = 5'd31; exp_d[3] = 5'd0;
      for (int s = 0; s < 4; s++) do_push(2'(s), 5'd5, 5'd12);
      checks++;
      if (busy_mask !== 32'h8000_1020 || count !== 3'd4) begin
         failures++;
         $display("FAIL select_mask: mask=%h cnt=%0d need 80001020/4", busy_mask, count);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wb_dest !== exp_d[i] || pop_valid !== 1'b1) begin
            failures++;
            $display("FAIL select_pop%0d: wb=%0d pv=%b need %0d/1", i, wb_dest, pop_valid, exp_d[i]);
         end
         do_pop();
      end
   endtask

   task automatic test_full();
      for (int i = 1; i <= 5; i++) begin
         do_push(2'b00, 5'(i), 5'd0);
         if (i == 4) begin
            checks++;
            if (push_ready !== 1'b0) begin
               failures++;
               $display("FAIL full_ready: got %b need 0", push_ready);
            end
         end
      end
      checks++;
      if (count !== 3'd4) begin
         failures++;
         $display("FAIL full_count: got %0d need 4", count);
      end
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (wb_dest !== 5'(i)) begin
            failures++;
            $display("FAIL full_pop%0d: got %0d need %0d", i, wb_dest, i);
         end
         do_pop();
      end
      checks++;
      if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_drain: cnt=%0d pv=%b pr=%b need 0/0/1", count, pop_valid, push_ready);
      end
   endtask

   task automatic test_back_to_back();
      do_push(2'b00, 5'd7, 5'd0);
      do_push(2'b00, 5'd8, 5'd0);
      dest_sel = 2'b01; inst_rd = 5'd20; push = 1'b1; pop = 1'b1;
      step();
      push = 1'b0; pop = 1'b0;
      checks++;
      if (count !== 3'd2 || wb_dest !== 5'd8) begin
         failures++;
         $display("FAIL b2b_pushpop: cnt=%0d wb=%0d need 2/8", count, wb_dest);
      end
      do_pop();
      checks++;
      if (wb_dest !== 5'd20) begin
         failures++;
         $display("FAIL b2b_second: got %0d need 20", wb_dest);
      end
      do_pop();
      for (int i = 1; i <= 4; i++) do_push(2'b00, 5'(i), 5'd0);
      dest_sel = 2'b00; inst_rt = 5'd9; push = 1'b1; pop = 1'b1;
      step();
      push = 1'b0; pop = 1'b0;
      checks++;
      if (count !== 3'd3 || wb_dest !== 5'd2 || busy_mask[9] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_full: cnt=%0d wb=%0d busy9=%b need 3/2/0", count, wb_dest, busy_mask[9]);
      end
      for (int i = 2; i <= 4; i++) do_pop();
      checks++;
      if (count !== 3'd0 || pop_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain: cnt=%0d pv=%b need 0/0", count, pop_valid);
      end
   endtask

   task automatic test_hazard();
      query_a = 5'd10; query_b = 5'd0;
      do_push(2'b00, 5'd10, 5'd0);
      do_push(2'b00, 5'd10, 5'd0);
      checks++;
      if (hazard !== 1'b1 || busy_mask !== 32'h0000_0400) begin
         failures++;
         $display("FAIL hz_two: hz=%b mask=%h need 1/00000400", hazard, busy_mask);
      end
      do_pop();
      checks++;
      if (hazard !== 1'b1) begin
         failures++;
         $display("FAIL hz_after_first_pop: got %b need 1", hazard);
      end
      do_pop();
      checks++;
      if (hazard !== 1'b0 || busy_mask !== 32'd0) begin
         failures++;
         $display("FAIL hz_after_second_pop: hz=%b mask=%h need 0/0", hazard, busy_mask);
      end
      do_push(2'b11, 5'd10, 5'd10);
      checks++;
      if (count !== 3'd1 || pop_valid !== 1'b1 || busy_mask !== 32'd0 || hazard !== 1'b0) begin
         failures++;
         $display("FAIL hz_zero_dest: cnt=%0d pv=%b mask=%h hz=%b need 1/1/0/0",
                  count, pop_valid, busy_mask, hazard);
      end
      do_pop();
      do_pop();
      checks++;
      if (count !== 3'd0 || pop_valid !== 1'b0 || wb_dest !== 5'd0 || push_ready !== 1'b1) begin
         failures++;
         $display("FAIL pop_empty: cnt=%0d pv=%b wb=%0d pr=%b need 0/0/0/1",
                  count, pop_valid, wb_dest, push_ready);
      end
      query_a = 5'd0;
   endtask

   task automatic test_bypass();
      dest_sel = 2'b01; inst_rd = 5'd17; push = 1'b1; pop = 1'b1;
      #1;
`ifdef REGDEST_WB_BYPASS_EN
      checks++;
      if (wb_dest !== 5'd17 || pop_valid !== 1'b1) begin
         failures++;
         $display("FAIL bypass_same_cycle: wb=%0d pv=%b need 17/1", wb_dest, pop_valid);
      end
`else
      checks++;
      if (wb_dest !== 5'd0 || pop_valid !== 1'b0) begin
         failures++;
         $display("FAIL nobypass_same_cycle: wb=%0d pv=%b need 0/0", wb_dest, pop_valid);
      end
`endif
      step();
      push = 1'b0; pop = 1'b0;
      #1;
`ifdef REGDEST_WB_BYPASS_EN
      checks++;
      if (count !== 3'd0 || pop_valid !== 1'b0) begin
         failures++;
         $display("FAIL bypass_after: cnt=%0d pv=%b need 0/0", count, pop_valid);
      end
`else
      checks++;
      if (count !== 3'd1 || wb_dest !== 5'd17 || pop_valid !== 1'b1) begin
         failures++;
         $display("FAIL nobypass_after: cnt=%0d wb=%0d pv=%b need 1/17/1", count, wb_dest, pop_valid);
      end
      do_pop();
`endif
   endtask

   initial begin
      dest_sel = 2'b00; inst_rt = '0; inst_rd = '0;
      push = 1'b0; pop = 1'b0; query_a = '0; query_b = '0;
      test_reset();
      test_select();
      test_full();
      test_back_to_back();
      test_hazard();
      test_bypass();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regdest_wb_queue.md
Name: regdest_wb_queue

Overview:
- Parametrised successor to the register-destination mux.
- Selects the write-back destination (rt, rd, link or zero) at issue time and holds it in a small FIFO of pending write-backs for multicycle operations (load, mult/div).
- Releases each destination in order when the operation completes.
- Exports a busy mask and a two-port hazard query for the control unit's stall logic.

Parameters:
- REG_ADDR_W, 5, width of a register address.
- DEPTH, 4, number of pending write-back entries (power of 2, ≥2).
- LINK_REG, 31, register number selected by the link code.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dest_sel  in  2  00 rt, 01 rd, 10 LINK_REG, 11 zero (no write).
- inst_rt  in  REG_ADDR_W  instruction bits [20:16].
- inst_rd  in  REG_ADDR_W  instruction bits [15:11].
- push  in  1  issue request; enqueue the selected destination.
- push_ready  out  1  queue can accept a push (= !full).
- pop  in  1  write-back completes; dequeue head.
- pop_valid  out  1  head entry valid.
- wb_dest  out  REG_ADDR_W  head destination (0 when empty).
- count  out  $clog2(DEPTH)+1  occupied entries.
- busy_mask  out  2**REG_ADDR_W  bit r set if any valid entry targets r; bit 0 always 0.
- query_a, query_b  in  REG_ADDR_W  source registers of the instruction in decode.
- hazard  out  1  busy_mask[query_a] | busy_mask[query_b].

Behaviour:
- Reset (async, immediate): rd/wr pointers 0, count 0, all valid bits 0, so pop_valid=0, wb_dest=0, busy_mask=0, hazard=0, push_ready=1. Entry contents need not clear.
- Destination select is combinational: 00→inst_rt, 01→inst_rd, 10→LINK_REG[REG_ADDR_W-1:0], 11→0.
- Push is accepted iff push && push_ready. The selected address is written at the tail on the rising edge. If the queue was empty, it is visible on wb_dest/pop_valid the next cycle (latency 1).
- Pop is accepted iff pop && pop_valid. The head advances on the edge.
- Pop while empty is ignored with no state change.
- Push while full is ignored. Push_ready does not look at pop: push+pop when full drops the push.
- Push+pop in the same cycle when non-empty and not full: both happen, count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full = count==DEPTH; empty = count==0.
- A zero destination (dest_sel=11 or address 0) still occupies an entry, preserving completion order, but never sets busy_mask.
- busy_mask and hazard are combinational from the registered entries and valid bits. They are not affected by same-cycle push/pop.
- Multiple entries may target the same register. The bit stays set until the last matching entry pops.
- All outputs other than busy_mask/hazard/push_ready are driven from registers. No combinational path from push/pop to outputs.

Optional Feature:
- Macro REGDEST_WB_BYPASS_EN.
- Defined: when empty, push && pop in the same cycle forwards the selected destination combinationally. wb_dest = selected address, pop_valid=1 that cycle, nothing stored, count stays 0.
- Not defined: same case enqueues normally, the pop is ignored (empty), and the entry is visible next cycle.

Decomposition:
- Package mips_regdest_pkg holds:
  - DEST_RT=2'b00, DEST_RD=2'b01, DEST_LINK=2'b10, DEST_ZERO=2'b11
  - default REG_ADDR_W and LINK_REG constants
- One combinational sub-module, regdest_sel: dest_sel, rt, rd → address. It is reusable by the single-cycle datapath. FIFO and mask logic stay in the top.

Test Plan:
- Reset mid-operation: push 3 entries, assert reset between edges → all outputs return to reset values immediately; next push of rd=9 gives wb_dest=9 one cycle later.
- Select codes: push with rt=5, rd=12 and dest_sel 00,01,10,11 → pops return 5, 12, 31, 0 in order. busy_mask after all pushes = bits 5, 12, 31 only.
- Full/overflow: DEPTH=4, push 5 times (rt=1..5) → push_ready=0 after 4th, 5th dropped, count=4, pops yield 1,2,3,4.
- Simultaneous: with 2 entries (7, 8), push rd=20 and pop in the same cycle → count stays 2, next wb_dest=8, then 20. Push+pop at full → push dropped.
- Hazard/duplicates: push rt=10 twice, query_a=10 → hazard=1 after the first pop, 0 after the second. query_b=0 → never a hazard. Pop on empty → no change.
- Bypass, both builds: empty queue, push rd=17 + pop → with the macro, same-cycle wb_dest=17, pop_valid=1, count stays 0. Without it, count=1 and wb_dest=17 next cycle.
